uart_boot_loader: RTL and testbench

//   Receive end of the serial program-load link into selen_top. The link sends bytes
//   as: start bit (0), 8 data bits MSB first, stop bit (1), back to back.
//   The block deserializes the bytes and packs every 4 bytes into one 32-bit word,

---
 rtl/uart_boot_loader.sv | 205 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader
// Purpose  : Serial program-load receiver. Deserializes 8N1 bytes (MSB first),
//            packs every four bytes into a 32-bit word (first byte in [31:24])
//            and writes the words to consecutive addresses through a
//            pipelined Wishbone write master with one outstanding write.
// Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          WORDS        = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        uart_rx,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_data_o,
    input  logic        wb_ack,
    input  logic        wb_stall,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_vld,
    output logic        frame_err,
    output logic        overrun_err,
    output logic        load_done
);

    localparam logic [2:0]  c_IDLE      = 3'd0;
    localparam logic [2:0]  c_START     = 3'd1;
    localparam logic [2:0]  c_DATA      = 3'd2;
    localparam logic [2:0]  c_STOP      = 3'd3;
    localparam logic [2:0]  c_WAIT_HI   = 3'd4;
    localparam logic [15:0] c_HALF      = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] c_LAST      = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] c_LAST_WORD = 32'(WORDS - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        w_rx;
    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shreg;
    logic        r_done;
    logic        r_bad;
    logic [7:0]  r_done_byte;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word;
    logic [31:0] r_word_cnt;

    assign w_rx = r_sync2;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM. With a half-bit of zero the detecting sample doubles as
    // the start-bit check, so one bit is consumed per cycle at CLKS_PER_BIT=1.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_shreg     <= 8'd0;
            r_done      <= 1'b0;
            r_bad       <= 1'b0;
            r_done_byte <= 8'd0;
            frame_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_bad  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!w_rx) begin
                        r_bit_idx <= 3'd0;
                        if (c_HALF == 16'd0) begin
                            r_state <= c_DATA;
                            r_cnt   <= 16'd0;
                        end else begin
                            r_state <= c_START;
                            r_cnt   <= 16'd1;
                        end
                    end
                end
                c_START: begin
                    if (r_cnt == c_HALF) begin
                        r_cnt   <= 16'd0;
                        r_state <= w_rx ? c_IDLE : c_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_DATA: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt     <= 16'd0;
                        r_shreg   <= {r_shreg[6:0], w_rx};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_STOP: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt <= 16'd0;
                        if (w_rx) begin
                            r_done      <= 1'b1;
                            r_done_byte <= r_shreg;
                            r_state     <= c_IDLE;
                        end else begin
                            r_bad     <= 1'b1;
                            frame_err <= 1'b1;
                            r_state   <= c_WAIT_HI;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_WAIT_HI: begin
                    if (w_rx) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Byte publication, word assembly and the single-outstanding Wishbone
    // write. A completed word only starts a write when no cycle is open, so
    // the start and ack branches below never act in the same clock.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_byte     <= 8'd0;
            rx_byte_vld <= 1'b0;
            r_byte_cnt  <= 2'd0;
            r_word      <= 24'd0;
            r_word_cnt  <= 32'd0;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            wb_we       <= 1'b0;
            wb_sel      <= 4'h0;
            wb_addr     <= BASE_ADDR;
            wb_data_o   <= 32'd0;
            overrun_err <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            rx_byte_vld <= r_done;
            if (r_done) begin
                rx_byte <= r_done_byte;
            end

            if (r_bad) begin
                r_byte_cnt <= 2'd0;
            end else if (r_done && !load_done) begin
                r_word     <= {r_word[15:0], r_done_byte};
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'd3) begin
                    if (!wb_cyc) begin
                        wb_data_o <= {r_word, r_done_byte};
                        wb_cyc    <= 1'b1;
                        wb_stb    <= 1'b1;
                        wb_we     <= 1'b1;
                        wb_sel    <= 4'hF;
                    end else begin
                        overrun_err <= 1'b1;
                    end
                end
            end

            if (wb_cyc) begin
                if (wb_stb && !wb_stall) begin
                    wb_stb <= 1'b0;
                end
                if (wb_ack) begin
                    wb_cyc     <= 1'b0;
                    wb_stb     <= 1'b0;
                    wb_we      <= 1'b0;
                    wb_sel     <= 4'h0;
                    wb_addr    <= wb_addr + 32'd4;
                    r_word_cnt <= r_word_cnt + 32'd1;
                    if (r_word_cnt == c_LAST_WORD) begin
                        load_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_boot_loader
// Purpose  : Scoreboard bench for uart_boot_loader. Instance A runs at one
//            clock per bit with a full word budget; instance B runs at four
//            clocks per bit with a two-word budget.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_rx, a_ack, a_stall;
    logic        a_cyc, a_stb, a_we, a_vld, a_ferr, a_oerr, a_done;
    logic [3:0]  a_sel;
    logic [31:0] a_addr, a_data;
    logic [7:0]  a_byte;

    logic        b_rx, b_ack, b_stall;
    logic        b_cyc, b_stb, b_we, b_vld, b_ferr, b_oerr, b_done;
    logic [3:0]  b_sel;
    logic [31:0] b_addr, b_data;
    logic [7:0]  b_byte;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [7:0]  exp_a_bytes[$];
    logic [7:0]  exp_b_bytes[$];
    wr_t         exp_a_wr[$];
    wr_t         exp_b_wr[$];
    wr_t         a_cur;

    int          a_cfg_stall = 0;
    int          a_cfg_ack   = 1;
    int          a_st        = 0;
    int          a_ak        = 0;
    bit          a_seen      = 1'b0;
    int          b_wr_cnt    = 0;
    int          b_acks      = 0;
    bit          b_chk_next  = 1'b0;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .CLKS_PER_BIT (1),
        .BASE_ADDR    (32'h0),
        .WORDS        (1024)
    ) u_dut_a (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .uart_rx     (a_rx),
        .wb_cyc      (a_cyc),
        .wb_stb      (a_stb),
        .wb_we       (a_we),
        .wb_sel      (a_sel),
        .wb_addr     (a_addr),
        .wb_data_o   (a_data),
        .wb_ack      (a_ack),
        .wb_stall    (a_stall),
        .rx_byte     (a_byte),
        .rx_byte_vld (a_vld),
        .frame_err   (a_ferr),
        .overrun_err (a_oerr),
        .load_done   (a_done)
    );

    uart_boot_loader #(
        .CLKS_PER_BIT (4),
        .BASE_ADDR    (32'h0),
        .WORDS        (2)
    ) u_dut_b (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .uart_rx     (b_rx),
        .wb_cyc      (b_cyc),
        .wb_stb      (b_stb),
        .wb_we       (b_we),
        .wb_sel      (b_sel),
        .wb_addr     (b_addr),
        .wb_data_o   (b_data),
        .wb_ack      (b_ack),
        .wb_stall    (b_stall),
        .rx_byte     (b_byte),
        .rx_byte_vld (b_vld),
        .frame_err   (b_ferr),
        .overrun_err (b_oerr),
        .load_done   (b_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Slave A: configurable stall length and ack delay after acceptance.
    initial begin
        a_ack   = 1'b0;
        a_stall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            a_ack   = 1'b0;
            a_stall = 1'b0;
            if (a_cyc !== 1'b1) begin
                a_seen = 1'b0;
            end else if (a_stb === 1'b1) begin
                if (!a_seen) begin
                    a_seen = 1'b1;
                    a_st   = a_cfg_stall;
                end
                if (a_st > 0) begin
                    a_stall = 1'b1;
                    a_st--;
                end else begin
                    a_ak  = a_cfg_ack;
                    a_ack = (a_ak == 0);
                end
            end else begin
                a_ak--;
                a_ack = (a_ak <= 0);
            end
        end
    end

    // Slave B: never stalls, acks in the same cycle the strobe is accepted.
    initial begin
        b_ack   = 1'b0;
        b_stall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            b_ack = (b_cyc === 1'b1) && (b_stb === 1'b1);
        end
    end

    // Monitor A: bytes and writes popped from the scoreboard as they appear.
    always @(negedge clk) begin : mon_a
        logic [7:0] eb;
        wr_t        ew;
        if (a_vld === 1'b1) begin
            if (exp_a_bytes.size() == 0) begin
                check_eq("a_byte_unexpected", 32'(exp_a_bytes.size()), 32'd1);
            end else begin
                eb = exp_a_bytes.pop_front();
                check_eq("a_byte", {24'd0, a_byte}, {24'd0, eb});
            end
        end
        if (a_cyc === 1'b1 && a_stb === 1'b1 && a_stall === 1'b0) begin
            if (exp_a_wr.size() == 0) begin
                check_eq("a_wr_unexpected", 32'(exp_a_wr.size()), 32'd1);
            end else begin
                ew    = exp_a_wr.pop_front();
                a_cur = ew;
                check_eq("a_wr_addr", a_addr, ew.addr);
                check_eq("a_wr_data", a_data, ew.data);
                check_eq("a_wr_sel_we", {27'd0, a_sel, a_we}, {27'd0, 4'hF, 1'b1});
            end
        end
        if (a_cyc === 1'b1 && a_ack === 1'b1) begin
            check_eq("a_ack_addr", a_addr, a_cur.addr);
            check_eq("a_ack_data", a_data, a_cur.data);
        end
    end

    // Monitor B: scoreboard plus load_done timing around each ack.
    always @(negedge clk) begin : mon_b
        logic [7:0] eb;
        wr_t        ew;
        if (b_vld === 1'b1) begin
            if (exp_b_bytes.size() == 0) begin
                check_eq("b_byte_unexpected", 32'(exp_b_bytes.size()), 32'd1);
            end else begin
                eb = exp_b_bytes.pop_front();
                check_eq("b_byte", {24'd0, b_byte}, {24'd0, eb});
            end
        end
        if (b_cyc === 1'b1 && b_stb === 1'b1 && b_stall === 1'b0) begin
            b_wr_cnt++;
            if (exp_b_wr.size() == 0) begin
                check_eq("b_wr_unexpected", 32'(exp_b_wr.size()), 32'd1);
            end else begin
                ew = exp_b_wr.pop_front();
                check_eq("b_wr_addr", b_addr, ew.addr);
                check_eq("b_wr_data", b_data, ew.data);
            end
        end
        if (b_chk_next) begin
            b_chk_next = 1'b0;
            check_eq("b_done_after_ack", {31'd0, b_done}, (b_acks == 2) ? 32'd1 : 32'd0);
        end
        if (b_cyc === 1'b1 && b_ack === 1'b1) begin
            check_eq("b_done_at_ack", {31'd0, b_done}, 32'd0);
            b_acks++;
            b_chk_next = 1'b1;
        end
    end

    task automatic drive_rx(input bit inst_b, input logic v, input int n);
        if (inst_b) b_rx = v;
        else        a_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit inst_b, input logic [7:0] d, input logic stop_bit);
        int n = inst_b ? 4 : 1;
        if (stop_bit) begin
            if (inst_b) exp_b_bytes.push_back(d);
            else        exp_a_bytes.push_back(d);
        end
        drive_rx(inst_b, 1'b0, n);
        for (int i = 7; i >= 0; i--) drive_rx(inst_b, d[i], n);
        drive_rx(inst_b, stop_bit, n);
    endtask

    task automatic send_word(input bit inst_b, input logic [31:0] w,
                             input logic [31:0] addr, input bit want_write);
        wr_t e;
        e.addr = addr;
        e.data = w;
        if (want_write) begin
            if (inst_b) exp_b_wr.push_back(e);
            else        exp_a_wr.push_back(e);
        end
        for (int i = 3; i >= 0; i--) send_byte(inst_b, w[8*i +: 8], 1'b1);
    endtask

    task automatic wait_drain(input bit inst_b, input int limit);
        int k = 0;
        while (k < limit && (inst_b ? (exp_b_bytes.size() + exp_b_wr.size() != 0 || b_cyc)
                                    : (exp_a_bytes.size() + exp_a_wr.size() != 0 || a_cyc))) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (inst_b) check_eq("b_drain", 32'(exp_b_bytes.size() + exp_b_wr.size()) + {31'd0, b_cyc}, 32'd0);
        else        check_eq("a_drain", 32'(exp_a_bytes.size() + exp_a_wr.size()) + {31'd0, a_cyc}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_rx  = 1'b1;
        b_rx  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_a(input string tag);
        check_eq({tag, "_ctl"}, {21'd0, a_cyc, a_stb, a_we, a_sel, a_vld, a_ferr, a_oerr, a_done}, 32'd0);
        check_eq({tag, "_addr"}, a_addr, 32'h0);
        check_eq({tag, "_data"}, a_data, 32'h0);
        check_eq({tag, "_byte"}, {24'd0, a_byte}, 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        rst_n = 1'b0;
        a_rx  = 1'b1;
        b_rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_a("rst_a");
        check_eq("rst_b_ctl", {21'd0, b_cyc, b_stb, b_we, b_sel, b_vld, b_ferr, b_oerr, b_done}, 32'd0);

        // Single word, ack one cycle after the strobe is accepted.
        send_word(1'b0, 32'hDEADBEEF, 32'h0, 1'b1);
        wait_drain(1'b0, 200);
        check_eq("t1_flags", {29'd0, a_ferr, a_oerr, a_done}, 32'd0);

        // Three words back to back.
        do_reset();
        send_word(1'b0, 32'h00000013, 32'h0, 1'b1);
        send_word(1'b0, 32'h11223344, 32'h4, 1'b1);
        send_word(1'b0, 32'hFFFFFFFF, 32'h8, 1'b1);
        wait_drain(1'b0, 200);
        check_eq("t2_flags", {29'd0, a_ferr, a_oerr, a_done}, 32'd0);
        check_eq("t2_next_addr", a_addr, 32'hC);

        // Framing error on the second byte discards the partial word.
        do_reset();
        send_byte(1'b0, 8'h55, 1'b1);
        send_byte(1'b0, 8'hA5, 1'b0);
        drive_rx(1'b0, 1'b1, 4);
        send_word(1'b0, 32'h01020304, 32'h0, 1'b1);
        wait_drain(1'b0, 200);
        check_eq("t3_flags", {29'd0, a_ferr, a_oerr, a_done}, 32'b100);

        // Stalled, slow write while a second word completes: overrun.
        do_reset();
        a_cfg_stall = 5;
        a_cfg_ack   = 60;
        send_word(1'b0, 32'hCAFEF00D, 32'h0, 1'b1);
        send_word(1'b0, 32'h0BADBEEF, 32'h0, 1'b0);
        wait_drain(1'b0, 400);
        check_eq("t4_overrun", {29'd0, a_ferr, a_oerr, a_done}, 32'b010);
        a_cfg_stall = 0;
        a_cfg_ack   = 1;
        send_word(1'b0, 32'h5A5A1234, 32'h4, 1'b1);
        wait_drain(1'b0, 200);
        check_eq("t4_after", a_addr, 32'h8);

        // Reset mid-byte and mid-write.
        do_reset();
        send_word(1'b0, 32'h00C0FFEE, 32'h0, 1'b1);
        wait_drain(1'b0, 200);
        drive_rx(1'b0, 1'b0, 4);
        do_reset();
        check_reset_a("t6_mid_byte");
        a_cfg_ack = 60;
        send_word(1'b0, 32'h12345678, 32'h0, 1'b1);
        k = 0;
        while (k < 20 && a_cyc !== 1'b1) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("t6_wr_started", {31'd0, a_cyc}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        check_reset_a("t6_mid_write");
        a_cfg_ack = 1;
        send_word(1'b0, 32'hAABBCCDD, 32'h0, 1'b1);
        wait_drain(1'b0, 200);

        // Word budget of two on the slower instance, then a start glitch.
        b_acks   = 0;
        b_wr_cnt = 0;
        send_word(1'b1, 32'h11111111, 32'h0, 1'b1);
        send_word(1'b1, 32'h22222222, 32'h4, 1'b1);
        send_word(1'b1, 32'h33333333, 32'h8, 1'b0);
        wait_drain(1'b1, 400);
        check_eq("t5_wr_count", 32'(b_wr_cnt), 32'd2);
        check_eq("t5_state", {28'd0, b_cyc, b_ferr, b_oerr, b_done}, 32'b0001);
        drive_rx(1'b1, 1'b0, 1);
        drive_rx(1'b1, 1'b1, 24);
        check_eq("t5_glitch_flags", {28'd0, b_vld, b_ferr, b_oerr, b_cyc}, 32'd0);
        check_eq("t5_glitch_byte", {24'd0, b_byte}, 32'h33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
